// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: walks N operand pairs from two synchronous RAMs through one shared mac.
// Optional watchdog on the mac handshake is enabled by defining MAC_SEQ_CTRL_TIMEOUT_EN.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_terms,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_start,
  input  logic [DATA_WIDTH-1:0] mac_dout,
  input  logic                  mac_busy
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_LOAD    = 3'd3,
    S_ISSUE   = 3'd4,
    S_WAIT_HI = 3'd5,
    S_WAIT_LO = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH:0] N_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
  logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  mac_start_q, mac_start_d;
  logic                  last_s;
  logic                  tmo_hit_s;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
  logic [31:0]           tmo_q, tmo_d;
  logic                  err_q, err_d;

  assign tmo_hit_s = (tmo_q == 32'(TIMEOUT));
`else
  assign tmo_hit_s = 1'b0;
`endif

  assign last_s = ({1'b0, idx_q} == (n_q - (ADDR_WIDTH+1)'(1)));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    result_d = result_q;
    mac_a_d  = mac_a_q;
    mac_b_d  = mac_b_q;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (num_terms == {(ADDR_WIDTH+1){1'b0}}) begin
            result_d = {DATA_WIDTH{1'b0}};
            state_d  = S_DONE;
          end else begin
            n_d     = (num_terms > N_MAX) ? N_MAX : num_terms;
            idx_d   = {ADDR_WIDTH{1'b0}};
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        mac_a_d = w_data;
        mac_b_d = x_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (mac_busy) begin
          state_d = S_WAIT_LO;
        end else if (tmo_hit_s) begin
          state_d = S_DONE;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (!mac_busy) begin
          if (last_s) begin
            result_d = mac_dout;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end else if (tmo_hit_s) begin
          state_d = S_DONE;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    // Counter restarts on every state change so each wait phase gets its own budget
    if ((state_d != state_q) || ((state_q != S_WAIT_HI) && (state_q != S_WAIT_LO))) begin
      tmo_d = 32'd0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end
`endif

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    mem_rd_en_d = (state_d == S_FETCH);
    mac_clr_d   = (state_d == S_CLEAR);
    mac_start_d = (state_d == S_ISSUE);
    addr_d      = (state_d == S_FETCH) ? idx_d : addr_q;
  end

  // FSM state, job context and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= {(ADDR_WIDTH+1){1'b0}};
      idx_q       <= {ADDR_WIDTH{1'b0}};
      addr_q      <= {ADDR_WIDTH{1'b0}};
      result_q    <= {DATA_WIDTH{1'b0}};
      mac_a_q     <= {DATA_WIDTH{1'b0}};
      mac_b_q     <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_start_q <= 1'b0;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
      tmo_q       <= 32'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      result_q    <= result_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_en_q <= mem_rd_en_d;
      mac_clr_q   <= mac_clr_d;
      mac_start_q <= mac_start_d;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign mem_rd_en = mem_rd_en_q;
  assign w_addr    = addr_q;
  assign x_addr    = addr_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_start = mac_start_q;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with behavioural operand RAMs and a variable-latency mac model.
module tb_mac_seq_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW:0]   num_terms;
  logic          busy, done, mem_rd_en, mac_clr, mac_start, mac_busy;
  logic [DW-1:0] result, w_data, x_data, mac_a, mac_b, mac_dout;
  logic [AW-1:0] w_addr, x_addr;
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .busy(busy), .done(done), .result(result),
    .mem_rd_en(mem_rd_en), .w_addr(w_addr), .x_addr(x_addr),
    .w_data(w_data), .x_data(x_data),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start),
    .mac_dout(mac_dout), .mac_busy(mac_busy)
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  // Operand RAMs: one-cycle read latency
  logic [DW-1:0] wmem [256];
  logic [DW-1:0] xmem [256];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      w_data <= wmem[w_addr];
      x_data <= xmem[x_addr];
    end
  end

  // Mac model: busy for mac_lat cycles, accumulates when busy falls; mac_lat=0 never responds
  int            mac_lat;
  int            bcnt;
  logic [DW-1:0] acc, pa, pb;
  always @(posedge clk) begin
    if (rst || mac_clr) begin
      acc  <= '0;
      bcnt <= 0;
    end else if (mac_start) begin
      pa   <= mac_a;
      pb   <= mac_b;
      bcnt <= mac_lat;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) acc <= acc + pa * pb;
    end
  end
  assign mac_busy = (bcnt != 0);
  assign mac_dout = acc;

  // Event monitor, sampled on the falling edge
  int            n_clr = 0, n_start = 0, n_done = 0, n_rd = 0, n_sbusy = 0, n_xmis = 0;
  logic [DW-1:0] last_a = '0, last_b = '0;
  logic [AW-1:0] addr_log [1024];
  always @(negedge clk) begin
    if (mac_clr) n_clr <= n_clr + 1;
    if (mac_start) begin
      n_start <= n_start + 1;
      last_a  <= mac_a;
      last_b  <= mac_b;
      if (mac_busy) n_sbusy <= n_sbusy + 1;
    end
    if (done) n_done <= n_done + 1;
    if (mem_rd_en) begin
      if (n_rd < 1024) addr_log[n_rd] <= w_addr;
      n_rd <= n_rd + 1;
      if (x_addr != w_addr) n_xmis <= n_xmis + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_clr"}, {31'd0, mac_clr}, 32'd0);
    chk({tag, "_mstart"}, {31'd0, mac_start}, 32'd0);
    chk({tag, "_a"}, mac_a, 32'd0);
    chk({tag, "_b"}, mac_b, 32'd0);
    chk({tag, "_waddr"}, {24'd0, w_addr}, 32'd0);
    chk({tag, "_xaddr"}, {24'd0, x_addr}, 32'd0);
  endtask

  // Launch a job and wait (bounded) for done; cyc = cycle of done counted from the accept edge
  task automatic run_job(input string tag, input logic [AW:0] n, input int budget, output int cyc);
    logic busy_ok;
    start     = 1'b1;
    num_terms = n;
    tick();
    start   = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < budget) begin
      busy_ok = busy_ok & busy;
      tick();
      cyc++;
    end
    busy_ok = busy_ok & busy;
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, s_clr, s_start, s_done, s_rd, guard;

    rst = 1'b1; start = 1'b0; num_terms = '0; mac_lat = 4;
    for (int i = 0; i < 256; i++) begin
      wmem[i] = 32'd0;
      xmem[i] = 32'd0;
    end
    wmem[0] = 32'd5; wmem[1] = 32'd2; wmem[2] = 32'd1;
    xmem[0] = 32'd3; xmem[1] = 32'd4; xmem[2] = 32'd7;

    tick(); tick(); tick();
    chk_all_zero("reset");
`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    chk("reset_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Single term: 1 clear + 8 term cycles (mac busy 4) + done
    s_clr = n_clr; s_start = n_start; s_done = n_done;
    run_job("one", 9'd1, 100, cyc);
    chk("one_result", result, 32'd15);
    chk("one_latency", cyc, 32'd10);
    chk("one_clr_cnt", n_clr - s_clr, 32'd1);
    chk("one_start_cnt", n_start - s_start, 32'd1);
    chk("one_a", last_a, 32'd5);
    chk("one_b", last_b, 32'd3);
    tick();
    chk("one_busy_after", {31'd0, busy}, 32'd0);
    chk("one_done_pulse", {31'd0, done}, 32'd0);
    chk("one_result_hold", result, 32'd15);
    chk("one_done_cnt", n_done - s_done, 32'd1);

    // Three terms, started back-to-back in the cycle after done
    s_start = n_start; s_done = n_done; s_rd = n_rd;
    run_job("three", 9'd3, 200, cyc);
    chk("three_result", result, 32'd30);
    chk("three_latency", cyc, 32'd26);
    chk("three_start_cnt", n_start - s_start, 32'd3);
    chk("three_rd_cnt", n_rd - s_rd, 32'd3);
    for (int i = 0; i < 3; i++) chk("three_addr", {24'd0, addr_log[s_rd + i]}, i);

    // Start during the DONE cycle is ignored
    start = 1'b1; num_terms = 9'd1;
    tick();
    start = 1'b0;
    chk("done_start_ign1", {31'd0, busy}, 32'd0);
    tick();
    chk("done_start_ign2", {31'd0, busy}, 32'd0);
    chk("three_done_cnt", n_done - s_done, 32'd1);

    // Zero terms: immediate done with result 0, mac untouched
    s_clr = n_clr; s_start = n_start; s_rd = n_rd;
    run_job("zero", 9'd0, 5, cyc);
    chk("zero_result", result, 32'd0);
    chk("zero_latency_le2", {31'd0, (cyc <= 2)}, 32'd1);
    chk("zero_clr_cnt", n_clr - s_clr, 32'd0);
    chk("zero_start_cnt", n_start - s_start, 32'd0);
    chk("zero_rd_cnt", n_rd - s_rd, 32'd0);
    tick();

    // Second start mid-job with a different N is ignored
    s_start = n_start;
    start = 1'b1; num_terms = 9'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; num_terms = 9'd1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("sb_done_seen", {31'd0, done}, 32'd1);
    chk("sb_result", result, 32'd30);
    chk("sb_start_cnt", n_start - s_start, 32'd3);
    tick();

    // Reset during WAIT_LO of the second term
    s_start = n_start;
    start = 1'b1; num_terms = 9'd3;
    tick();
    start = 1'b0;
    guard = 0;
    while ((n_start - s_start) < 2 && guard < 100) begin
      tick();
      guard++;
    end
    chk("rst_reach_term1", n_start - s_start, 32'd2);
    tick(); tick();
    chk("rst_in_wait_lo", {31'd0, mac_busy}, 32'd1);
    s_done = n_done;
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_no_done", n_done - s_done, 32'd0);
    chk("rst_idle", {31'd0, busy}, 32'd0);
    run_job("after_rst", 9'd1, 100, cyc);
    chk("after_rst_result", result, 32'd15);
    tick();

    // N above 2**ADDR_WIDTH clamps to 256 terms; mac busy 1 cycle
    mac_lat = 1;
    for (int i = 0; i < 256; i++) begin
      wmem[i] = 32'(i + 1);
      xmem[i] = 32'd1;
    end
    s_start = n_start; s_rd = n_rd;
    run_job("clamp", 9'd261, 3000, cyc);
    chk("clamp_result", result, 32'd32896);
    chk("clamp_start_cnt", n_start - s_start, 32'd256);
    chk("clamp_latency", cyc, 32'd1282);
    chk("clamp_last_addr", {24'd0, addr_log[s_rd + 255]}, 32'd255);
    tick();

`ifdef MAC_SEQ_CTRL_TIMEOUT_EN
    // Mac never raises busy: abort 11 cycles after entering WAIT_HI
    mac_lat = 0;
    run_job("tmo", 9'd1, 100, cyc);
    chk("tmo_latency", cyc, 32'd16);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_result_kept", result, 32'd32896);
    tick();
    chk("tmo_err_hold", {31'd0, err}, 32'd1);
    mac_lat = 4;
    wmem[0] = 32'd5; xmem[0] = 32'd3;
    start = 1'b1; num_terms = 9'd1;
    tick();
    start = 1'b0;
    chk("tmo_err_clear", {31'd0, err}, 32'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("tmo_next_result", result, 32'd15);
    tick();
`endif

    chk("no_start_while_busy", n_sbusy, 32'd0);
    chk("addr_pair_match", n_xmis, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
